// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity generator and PARITY state.
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit (low) for PRESCALE cycles
// DATA   | shadow[idx] on the line, PRESCALE cycles per bit
// PARITY | latched parity bit (parity build only)
// STOP   | stop bit (high) for PRESCALE cycles
module uart_tx #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    tick;

`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
    logic                    par_en_q, par_en_d;
`else
    logic                    unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end
`endif

    // The line and BUSY are computed from the next state so they change on the
    // same edge as the transition, with no extra pipeline cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        tick     = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
        par_en_d = par_en_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (DATA_VALID) begin
                    shadow_d = P_DATA;
`ifdef UART_TX_PARITY_EN
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
`endif
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                    tx_d    = shadow_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shadow_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued at acceptance and
// popped per serial bit while the frame is sampled one cycle at a time.
module tb_uart_tx;
    localparam int PRESCALE = 8;
    localparam int DW       = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          BUSY;

    int tests_run    = 0;
    int tests_failed = 0;

    logic exp_q[$];
    int   len_q[$];

    uart_tx #(.PRESCALE(PRESCALE), .DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit par_active(input logic pen);
`ifdef UART_TX_PARITY_EN
        return pen;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        int n;
        n = 0;
        exp_q.push_back(1'b0);
        n++;
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(d[i]);
            n++;
        end
        if (par_active(pen)) begin
            exp_q.push_back((^d) ^ ptyp);
            n++;
        end
        exp_q.push_back(1'b1);
        n++;
        len_q.push_back(n);
    endtask

    task automatic accept(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        push_frame(d, pen, ptyp);
        @(posedge CLK);
        #1;
    endtask

    // Entered #1 after the acceptance edge; leaves #1 after the edge that ends the stop bit.
    task automatic check_frame(input string tag, input bit hold, input bit inject);
        int   n;
        int   busy_cnt;
        int   match;
        logic b;
        n        = len_q.pop_front();
        busy_cnt = 0;
        if (!hold) begin
            DATA_VALID = 1'b0;
            P_DATA     = ~P_DATA;
            PAR_EN     = ~PAR_EN;
            PAR_TYP    = ~PAR_TYP;
        end
        for (int bi = 0; bi < n; bi++) begin
            b     = exp_q.pop_front();
            match = 0;
            for (int c = 0; c < PRESCALE; c++) begin
                if (bi != 0 || c != 0) begin
                    @(posedge CLK);
                    #1;
                end
                if (TX_OUT === b) match++;
                if (BUSY === 1'b1) busy_cnt++;
                if (inject && bi == 3 && c == 2) begin
                    P_DATA     = 8'h55;
                    DATA_VALID = 1'b1;
                end
                if (inject && bi == 3 && c == 3) DATA_VALID = 1'b0;
            end
            chk($sformatf("%s bit%0d cycles", tag, bi), match, PRESCALE);
        end
        @(posedge CLK);
        #1;
        chk($sformatf("%s busy_len", tag), busy_cnt, n * PRESCALE);
        chk($sformatf("%s busy_end", tag), BUSY, 1'b0);
        chk($sformatf("%s tx_end", tag), TX_OUT, 1'b1);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int ok;
        ok = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLK);
            #1;
            if (TX_OUT === 1'b1 && BUSY === 1'b0) ok++;
        end
        chk(tag, ok, cycles);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          rp, rt;
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", BUSY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        check_idle("idle after reset", 4);

        accept(8'hA5, 1'b1, 1'b0);
        chk("accept tx low", TX_OUT, 1'b0);
        chk("accept busy high", BUSY, 1'b1);
        check_frame("even_a5", 1'b0, 1'b0);

        accept(8'hA5, 1'b1, 1'b1);
        check_frame("odd_a5", 1'b0, 1'b0);

        accept(8'h07, 1'b1, 1'b0);
        check_frame("even_07", 1'b0, 1'b0);

        accept(8'h07, 1'b1, 1'b1);
        check_frame("odd_07", 1'b0, 1'b0);

        accept(8'h3C, 1'b0, 1'b0);
        check_frame("nopar_3c", 1'b0, 1'b0);

        accept(8'hF0, 1'b1, 1'b0);
        check_frame("reject", 1'b0, 1'b1);
        check_idle("reject no 0x55", 2 * PRESCALE);

        // held DATA_VALID: second frame must start one idle cycle after BUSY falls
        accept(8'h96, 1'b1, 1'b1);
        push_frame(8'h96, 1'b1, 1'b1);
        check_frame("held1", 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        check_frame("held2", 1'b0, 1'b0);

        accept(8'h3C, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        repeat (2 * PRESCALE + 3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("midframe reset tx", TX_OUT, 1'b1);
        chk("midframe reset busy", BUSY, 1'b0);
        exp_q.delete();
        len_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_idle("idle after midframe reset", 3 * PRESCALE);

        for (int k = 0; k < 20; k++) begin
            rd = DW'($urandom);
            rp = 1'($urandom);
            rt = 1'($urandom);
            accept(rd, rp, rt);
            check_frame($sformatf("rand%0d", k), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
